alarm_timer: RTL
================

Name: alarm_timer

Overview:
- Countdown timer that drives the anti-theft FSM's timer_status input.
- The FSM pulses start_timer with the selected interval on value; this block counts whole seconds from the system clock and returns a one-cycle expired pulse.
- Contains its own 1 Hz prescaler and a small IDLE/COUNT/DONE state machine.

Parameters:
- CLK_HZ, 27000000: clock cycles per second; prescaler terminal count is CLK_HZ-1. The bench overrides it to 4.
- WIDTH, 4: width of the interval value and of the seconds counter.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset; 0 resets the block.
- start_timer  input  1  one-cycle request from the FSM to (re)start the countdown.
- value  input  WIDTH  interval in seconds; sampled only on a start_timer edge.
- expired  output  1  one-cycle pulse at the end of the interval; connects to the FSM's timer_status.
- busy  output  1  high while counting.
- seconds_left  output  WIDTH  remaining whole seconds, for the display.
- one_hz  output  1  prescaler tick, one cycle wide, for the blink/debug LED.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; prescaler=0; seconds_left=0.
  - expired=0, busy=0, one_hz=0.
  - Release is synchronous to the next clock edge. Reset mid-count abandons the countdown, and no expired pulse follows.
- Prescaler:
  - Counts 0..CLK_HZ-1 and wraps.
  - one_hz=1 exactly while the count equals CLK_HZ-1.
  - Forced to 0 on every accepted start_timer, so the first second is full length.
- States:
  - IDLE:
    - start_timer=1 loads seconds_left<=value and clears the prescaler.
    - value!=0 -> COUNT; value==0 -> DONE.
  - COUNT:
    - busy=1. On each one_hz tick, seconds_left decrements.
    - A tick with seconds_left==1 sets seconds_left<=0 and moves to DONE.
  - DONE:
    - expired=1 for this single cycle only; next state is IDLE.
- Outputs: expired is a decode of state==DONE; busy is state==COUNT.
- Latency:
  - Let edge S be the edge that samples start_timer, with value N.
  - expired is high in the cycle beginning at edge S + N*CLK_HZ, for exactly 1 cycle.
  - N=0 gives expired in the cycle right after edge S.
- Restart:
  - start_timer in COUNT reloads value, clears the prescaler and restarts timing from that edge. The old countdown produces no pulse.
  - start_timer in DONE:
    - expired still pulses this cycle.
    - The new load is accepted, and the next state is COUNT (or DONE again if value==0).
- Input sampling:
  - value changes while not starting are ignored.
  - seconds_left holds 0 in IDLE after an expiry and never wraps below 0.
- start_timer held high for several cycles reloads each cycle. The FSM guarantees single-cycle pulses.
- Widths: maximum interval is 2^WIDTH-1 seconds. The prescaler is sized to hold CLK_HZ-1.

Test Plan:
- CLK_HZ=4, pulse start_timer with value=3:
  - seconds_left reads 3, 2, 1, 0 after edges S+4, S+8, S+12.
  - expired=1 only in the cycle after edge S+12; busy falls at S+12.
- value=0 start -> expired=1 in the cycle right after edge S, busy never asserts, seconds_left=0.
- value=3 start at S, then start with value=2 at S+6 -> no pulse near S+12; expired only after edge S+14.
- value=3 start, drive value=9 at S+2 -> countdown unaffected; expired after S+12.
- reset=0 at S+5 during a value=3 count -> all outputs 0 immediately (asynchronous); no expired through S+20; a fresh start after release times correctly.
- start_timer with value=1 coincident with a DONE cycle -> that expired pulse is present; a second expired follows 4 cycles later (edge +4).

Source files
------------

// File: rtl/alarm_timer_if.sv
// Handshake bundle between the anti-theft FSM and its countdown timer.
// The FSM (master) requests a countdown; the timer (slave) reports
// progress and the one-cycle expiry pulse.
interface alarm_timer_if #(
    parameter int WIDTH = 4
);
    logic             start_timer;
    logic [WIDTH-1:0] value;
    logic             expired;
    logic             busy;
    logic [WIDTH-1:0] seconds_left;
    logic             one_hz;

    modport master (
        output start_timer,
        output value,
        input  expired,
        input  busy,
        input  seconds_left,
        input  one_hz
    );

    modport slave (
        input  start_timer,
        input  value,
        output expired,
        output busy,
        output seconds_left,
        output one_hz
    );
endinterface

// File: rtl/alarm_timer.sv
// Whole-second countdown timer for the anti-theft FSM.
// A free-running prescaler divides the system clock down to a one-cycle
// tick per second; a small IDLE/COUNT/DONE machine counts the requested
// interval down and answers with a single-cycle expired pulse.
module alarm_timer #(
    parameter int CLK_HZ = 27000000,
    parameter int WIDTH  = 4
) (
    input  logic         clock,
    input  logic         reset,
    alarm_timer_if.slave bus
);

    // Prescaler must hold CLK_HZ-1; keep at least one bit for CLK_HZ==1.
    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } timerState_t;

    timerState_t      state_q;
    logic [PW-1:0]    prescCount_q;
    logic [PW-1:0]    prescCount_d;
    logic [WIDTH-1:0] secondsLeft_q;
    logic             expired_q;
    logic             busy_q;
    logic             tick;

    assign tick = (prescCount_q == PRESC_MAX);

    // Prescaler next value: wrap at terminal count, restart on every load so the first second is full length.
    always_comb begin
        prescCount_d = prescCount_q + PW'(1);
        if (bus.start_timer || tick) begin
            prescCount_d = '0;
        end
    end

    // Prescaler register, free running so the debug LED blinks even when idle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prescCount_q <= '0;
        end else begin
            prescCount_q <= prescCount_d;
        end
    end

    // Countdown FSM; a start request wins in every state, and expired/busy are registered alongside the state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            secondsLeft_q <= '0;
            expired_q     <= 1'b0;
            busy_q        <= 1'b0;
        end else if (bus.start_timer) begin
            secondsLeft_q <= bus.value;
            if (bus.value != '0) begin
                state_q   <= COUNT;
                busy_q    <= 1'b1;
                expired_q <= 1'b0;
            end else begin
                state_q   <= DONE;
                busy_q    <= 1'b0;
                expired_q <= 1'b1;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    busy_q    <= 1'b0;
                    expired_q <= 1'b0;
                end
                COUNT: begin
                    if (tick) begin
                        if (secondsLeft_q <= WIDTH'(1)) begin
                            secondsLeft_q <= '0;
                            state_q       <= DONE;
                            busy_q        <= 1'b0;
                            expired_q     <= 1'b1;
                        end else begin
                            secondsLeft_q <= secondsLeft_q - WIDTH'(1);
                        end
                    end
                end
                DONE: begin
                    state_q   <= IDLE;
                    busy_q    <= 1'b0;
                    expired_q <= 1'b0;
                end
                default: begin
                    state_q   <= IDLE;
                    busy_q    <= 1'b0;
                    expired_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.expired      = expired_q;
    assign bus.busy         = busy_q;
    assign bus.seconds_left = secondsLeft_q;
    assign bus.one_hz       = tick;

endmodule
